alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, handshaked successor to the single-cycle 48-bit ALU. It keeps the existing opcode encoding (AND/OR/ADD/SUB/SLT/NOR). It adds shifts and an iterative multi-cycle signed multiply, with registered result and zero outputs. It sits between the decode stage and writeback, using valid/ready on both sides so multi-cycle ops can stall the pipeline.

Parameters:
WIDTH, 48, operand/result width in bits (>= 8)
SHW, $clog2(WIDTH), localparam: shift-amount bits taken from b

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operands/control valid
in_ready  output  1  block can accept an op this cycle
a  input  WIDTH  signed operand A
b  input  WIDTH  signed operand B
control  input  4  opcode
out_valid  output  1  result/zero valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  signed result, registered
zero  output  1  result == 0, registered with result

Behaviour:
- Reset: single clk; reset is synchronous, active-low (rst_n sampled on rising clk). On reset: state=IDLE, in_ready=1, out_valid=0, result=0, zero=1. Reset overrides everything, including mid-multiply; any op in flight is discarded.
- Opcodes:
  - 0 AND; 1 OR; 2 ADD; 6 SUB; 7 SLT (signed a<b -> 1 else 0); C NOR.
  - 3 SLL, 4 SRL, 5 SRA by b[SHW-1:0]. Amount >= WIDTH: SLL/SRL give 0, SRA gives all copies of a's sign bit.
  - 8 MUL: low WIDTH bits of a*b, wrapping, sign-correct in two's complement.
  - All other codes: result 0, zero 1, single-cycle.
- ADD/SUB wrap modulo 2^WIDTH.
- States: IDLE, MUL, DONE.
  - IDLE: in_ready=1. Accept on in_valid at clk edge.
    - Single-cycle op: result/zero registered at that edge, go to DONE.
    - MUL: latch operands, clear accumulator, go to MUL.
  - MUL: in_ready=0, one shift-add step per cycle, iteration counter 0..WIDTH-1. After the WIDTH-th step, result/zero are registered and the state goes to DONE.
  - DONE: out_valid=1, in_ready=0. result/zero held stable until out_ready=1 at a clk edge, then IDLE.
- Latency from accept edge to out_valid high: 1 cycle for single-cycle ops, WIDTH cycles for MUL.
- Throughput: one op per 2 cycles minimum, since in_ready is low in DONE.
- Inputs are ignored when in_ready=0; a and b may change freely after acceptance.
- out_valid never drops without a handshake except on reset.

Optional Feature:
- Macro OVERFLOW_FLAG_EN.
- Defined: adds output port overflow (1 bit), registered with result and reset to 0.
  - overflow=1 on ADD/SUB signed overflow (operand sign rule).
  - overflow=1 on MUL when the full 2*WIDTH signed product does not sign-extend from bit WIDTH-1. This requires a 2*WIDTH accumulator.
  - overflow=0 for all other ops.
- Not defined: the port is absent and MUL uses a WIDTH-bit accumulator. All other behaviour is identical.

Test Plan:
- WIDTH=48, control=0, a=AAAA_AAAA_AAAA, b=5555_5555_5555, in_valid 1 cycle, out_ready=1 -> out_valid one cycle after accept; result=0, zero=1.
- SLT: a=-3, b=5 -> result=1, zero=0. Then a=5, b=-3 -> result=0, zero=1. Then SRA with a=8000_0000_0000, b=50 -> result=FFFF_FFFF_FFFF.
- MUL: a=-7, b=6 -> out_valid exactly 48 cycles after accept, result=-42 (FFFF_FFFF_FFD6), in_ready=0 throughout. An in_valid pulse during MUL is ignored.
- Backpressure: ADD a=1, b=1 with out_ready=0 for 5 cycles -> result=2 held stable, out_valid=1, in_ready=0. out_ready=1 -> IDLE next cycle.
- Reset mid-op: rst_n=0 for one edge at MUL iteration 10 -> out_valid=0, in_ready=1, result=0, zero=1. Subsequent SUB a=10, b=5 -> result=5.
- With OVERFLOW_FLAG_EN: ADD a=7FFF_FFFF_FFFF, b=1 -> result=8000_0000_0000, overflow=1. Then ADD 1+1 -> overflow=0.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked ALU with shifts and an iterative shift-add signed multiply.
// Optional macro OVERFLOW_FLAG_EN adds a registered signed-overflow output.
module alu_seq #(
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             overflow
`endif
);

  localparam int SHW = $clog2(WIDTH);
`ifdef OVERFLOW_FLAG_EN
  localparam int AW = 2 * WIDTH;
`else
  localparam int AW = WIDTH;
`endif

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h3;
  localparam logic [3:0] OP_SRL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_SLT = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;
  localparam logic [3:0] OP_NOR = 4'hC;

  localparam logic [SHW:0]   WIDTH_S  = (SHW + 1)'(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [1:0]       state;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [SHW-1:0]   cnt;

  logic [WIDTH-1:0] aluRes;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic             shBig;
  logic [AW-1:0]    addend;
  logic [AW-1:0]    accNext;
  logic             lastStep;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign shamt     = b[SHW-1:0];
  assign shBig     = ({1'b0, shamt} >= WIDTH_S);

  always_comb begin
    sum    = a + b;
    diff   = a - b;
    aluRes = '0;
    case (control)
      OP_AND:  aluRes = a & b;
      OP_OR:   aluRes = a | b;
      OP_ADD:  aluRes = sum;
      OP_SUB:  aluRes = diff;
      OP_SLT:  aluRes = {{(WIDTH - 1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  aluRes = shBig ? '0 : (a << shamt);
      OP_SRL:  aluRes = shBig ? '0 : (a >> shamt);
      OP_SRA:  aluRes = shBig ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> shamt);
      OP_NOR:  aluRes = ~(a | b);
      default: aluRes = '0;
    endcase
  end

  // The multiplier MSB carries negative weight, so the final step subtracts.
  always_comb begin
    lastStep = (cnt == CNT_LAST);
    addend   = mplier[0] ? mcand : '0;
    accNext  = lastStep ? (acc - addend) : (acc + addend);
  end

`ifdef OVERFLOW_FLAG_EN
  logic aluOvf;
  logic mulOvf;
  logic ovfReg;

  always_comb begin
    aluOvf = 1'b0;
    if (control == OP_ADD)
      aluOvf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    else if (control == OP_SUB)
      aluOvf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    mulOvf = !((&accNext[AW-1:WIDTH-1]) || !(|accNext[AW-1:WIDTH-1]));
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      ovfReg <= 1'b0;
    else if (state == IDLE && in_valid && control != OP_MUL)
      ovfReg <= aluOvf;
    else if (state == MUL && lastStep)
      ovfReg <= mulOvf;
  end

  assign overflow = ovfReg;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
      zero   <= 1'b1;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (control == OP_MUL) begin
              acc    <= '0;
              mcand  <= AW'($signed(a));
              mplier <= b;
              cnt    <= '0;
              state  <= MUL;
            end else begin
              result <= aluRes;
              zero   <= (aluRes == '0);
              state  <= DONE;
            end
          end
        end
        MUL: begin
          acc    <= accNext;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (lastStep) begin
            result <= accNext[WIDTH-1:0];
            zero   <= (accNext[WIDTH-1:0] == '0);
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver queues expected results, monitor checks
// each output handshake. Overflow is also checked when OVERFLOW_FLAG_EN is set.
module tb_alu_seq;

  localparam int W = 48;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h3;
  localparam logic [3:0] OP_SRL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_SLT = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;
  localparam logic [3:0] OP_NOR = 4'hC;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
`ifdef OVERFLOW_FLAG_EN
  logic         overflow;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         ovf;
  } expT;

  expT sbQueue[$];
  int  checks   = 0;
  int  failures = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
`ifdef OVERFLOW_FLAG_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("in_ready_wait", {63'd0, in_ready}, 64'd1);
  endtask

  // Issues one op and returns one tick after the accepting clock edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] va,
                               input logic [W-1:0] vb, input logic [W-1:0] expRes,
                               input logic expZero, input logic expOvf);
    expT e;
    @(posedge clk);
    #1;
    waitIdle();
    control  = op;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    e.res    = expRes;
    e.z      = expZero;
    e.ovf    = expOvf;
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
  endtask

  // Monitor: every output handshake pops one expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbQueue.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output: got result %h with nothing expected", result);
      end else begin
        expT e;
        e = sbQueue.pop_front();
        checkOutput("sb_result", {16'd0, result}, {16'd0, e.res});
        checkOutput("sb_zero", {63'd0, zero}, {63'd0, e.z});
`ifdef OVERFLOW_FLAG_EN
        checkOutput("sb_overflow", {63'd0, overflow}, {63'd0, e.ovf});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    logic irdyBad;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    control   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_result", {16'd0, result}, 64'd0);
    checkOutput("rst_zero", {63'd0, zero}, 64'd1);
`ifdef OVERFLOW_FLAG_EN
    checkOutput("rst_overflow", {63'd0, overflow}, 64'd0);
`endif
    rst_n = 1'b1;

    applyStimulus(OP_AND, 48'hAAAA_AAAA_AAAA, 48'h5555_5555_5555, 48'h0, 1'b1, 1'b0);
    checkOutput("and_out_valid_lat1", {63'd0, out_valid}, 64'd1);
    waitIdle();

    applyStimulus(OP_OR,  48'hAAAA_AAAA_AAAA, 48'h5555_5555_5555, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0);
    applyStimulus(OP_NOR, 48'hAAAA_AAAA_AAAA, 48'h5555_5555_5555, 48'h0, 1'b1, 1'b0);
    applyStimulus(OP_SLT, -48'sd3, 48'sd5, 48'h1, 1'b0, 1'b0);
    applyStimulus(OP_SLT, 48'sd5, -48'sd3, 48'h0, 1'b1, 1'b0);
    applyStimulus(OP_SRA, 48'h8000_0000_0000, 48'd50, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0);
    applyStimulus(OP_SRA, 48'h8000_0000_0000, 48'd4, 48'hF800_0000_0000, 1'b0, 1'b0);
    applyStimulus(OP_SRL, 48'h8000_0000_0000, 48'd4, 48'h0800_0000_0000, 1'b0, 1'b0);
    applyStimulus(OP_SRL, 48'h8000_0000_0000, 48'd50, 48'h0, 1'b1, 1'b0);
    applyStimulus(OP_SLL, 48'h1, 48'd47, 48'h8000_0000_0000, 1'b0, 1'b0);
    applyStimulus(OP_SLL, 48'h1, 48'd48, 48'h0, 1'b1, 1'b0);
    applyStimulus(OP_SUB, 48'd3, 48'd5, 48'hFFFF_FFFF_FFFE, 1'b0, 1'b0);
    applyStimulus(OP_SUB, 48'h8000_0000_0000, 48'd1, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b1);
    applyStimulus(OP_ADD, 48'h7FFF_FFFF_FFFF, 48'd1, 48'h8000_0000_0000, 1'b0, 1'b1);
    applyStimulus(OP_ADD, 48'd1, 48'd1, 48'd2, 1'b0, 1'b0);
    applyStimulus(OP_ADD, 48'h8000_0000_0000, 48'h8000_0000_0000, 48'h0, 1'b1, 1'b1);
    applyStimulus(4'h9, 48'd12, 48'd34, 48'h0, 1'b1, 1'b0);
    waitIdle();

    // Multiply with an ignored input pulse in the middle of the iteration.
    applyStimulus(OP_MUL, -48'sd7, 48'sd6, 48'hFFFF_FFFF_FFD6, 1'b0, 1'b0);
    k = 0;
    irdyBad = 1'b0;
    while (!out_valid && k < 200) begin
      if (in_ready) irdyBad = 1'b1;
      if (k == 5) begin
        control  = OP_ADD;
        a        = 48'd1;
        b        = 48'd1;
        in_valid = 1'b1;
      end
      if (k == 6) in_valid = 1'b0;
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("mul_latency", 64'(k), 64'd48);
    checkOutput("mul_in_ready_low", {63'd0, irdyBad}, 64'd0);
    waitIdle();

    applyStimulus(OP_MUL, -48'sd1, -48'sd1, 48'h1, 1'b0, 1'b0);
    waitIdle();
    applyStimulus(OP_MUL, 48'h1_0000_0000, 48'h1_0000, 48'h0, 1'b1, 1'b1);
    waitIdle();

    // Backpressure: result held while the consumer stalls.
    out_ready = 1'b0;
    applyStimulus(OP_ADD, 48'd1, 48'd1, 48'd2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_result", {16'd0, result}, 64'd2);
      checkOutput("bp_valid_ready", {62'd0, out_valid, in_ready}, 64'd2);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release", {62'd0, out_valid, in_ready}, 64'd1);

    // Reset in the middle of a multiply discards it.
    applyStimulus(OP_MUL, -48'sd7, 48'sd6, 48'hFFFF_FFFF_FFD6, 1'b0, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    sbQueue.delete();
    @(posedge clk);
    #1;
    checkOutput("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("midrst_result", {16'd0, result}, 64'd0);
    checkOutput("midrst_zero", {63'd0, zero}, 64'd1);
    rst_n = 1'b1;
    applyStimulus(OP_SUB, 48'd10, 48'd5, 48'd5, 1'b0, 1'b0);
    waitIdle();

    k = 0;
    while (sbQueue.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("sb_drained", 64'(sbQueue.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
